// File: rtl/operand_stack_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : operand_stack_buffer_if
// Purpose : Operand-stack control/data bundle (keypad, ALU and display side)
// Revision: 1.0 - initial release
// ============================================================================
interface operand_stack_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             store_digit;
    logic [WIDTH:0]   digit_in;
    logic             enter;
    logic             result_ready;
    logic [WIDTH:0]   result;
    logic             result_ovf;
    logic             op_take;
    logic             op_valid;
    logic [WIDTH+1:0] op_a;
    logic [WIDTH+1:0] op_b;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] disp_mag;
    logic             disp_sign;
    logic             disp_ovf;
    logic             stk_err;

    modport master (
        output clear, store_digit, digit_in, enter, result_ready, result, result_ovf, op_take,
        input  op_valid, op_a, op_b, count, full, empty, disp_mag, disp_sign, disp_ovf, stk_err
    );

    modport slave (
        input  clear, store_digit, digit_in, enter, result_ready, result, result_ovf, op_take,
        output op_valid, op_a, op_b, count, full, empty, disp_mag, disp_sign, disp_ovf, stk_err
    );
endinterface
`default_nettype wire

// File: rtl/operand_stack_buffer.sv
`default_nettype none
// ============================================================================
// Module  : operand_stack_buffer
// Purpose : Entry register, DEPTH-deep operand LIFO and display register
// Revision: 1.0 - initial release
// ============================================================================
module operand_stack_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    operand_stack_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = WIDTH + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [SW-1:0]  stack_q [DEPTH];
    logic [CW-1:0]  count_q, count_d;
    logic [WIDTH:0] entry_q, entry_d;
    logic [SW-1:0]  disp_q, disp_d;
    logic           err_q, err_d;

    logic           take;
    logic           ent_req;
    logic           res_ok;
    logic           ent_ok;
    logic [CW-1:0]  base;
    logic [CW-1:0]  free;
    logic [CW-1:0]  ent_idx;
    logic [SW-1:0]  op_a_w;
    logic [SW-1:0]  op_b_w;

    // Take retires first, so a same-cycle result lands in the freed slot.
    always_comb begin
        take    = bus.op_take && (count_q >= TWO_C);
        base    = take ? (count_q - TWO_C) : count_q;
        free    = DEPTH_C - base;
        ent_req = bus.enter && !bus.store_digit;
        res_ok  = bus.result_ready && (free != '0);
        ent_ok  = ent_req && (free > {{(CW-1){1'b0}}, res_ok});
        ent_idx = base + {{(CW-1){1'b0}}, res_ok};
        count_d = ent_idx + {{(CW-1){1'b0}}, ent_ok};
        err_d   = err_q | (bus.result_ready && !res_ok) | (ent_req && !ent_ok);

        entry_d = entry_q;
        disp_d  = disp_q;
        if (bus.store_digit) begin
            entry_d = bus.digit_in;
            disp_d  = {1'b0, bus.digit_in};
        end else if (ent_req) begin
            entry_d = '0;
            disp_d  = '0;
        end else if (bus.result_ready) begin
            disp_d  = {bus.result_ovf, bus.result};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            count_q <= '0;
            entry_q <= '0;
            disp_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (res_ok && (base == CW'(i))) begin
                    stack_q[i] <= {bus.result_ovf, bus.result};
                end else if (ent_ok && (ent_idx == CW'(i))) begin
                    stack_q[i] <= {1'b0, entry_q};
                end
            end
        end
    end

    always_comb begin
        op_a_w = '0;
        op_b_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((count_q >= TWO_C) && (CW'(i) == count_q - TWO_C)) begin
                op_a_w = stack_q[i];
            end
            if ((count_q >= TWO_C) && (CW'(i) == count_q - ONE_C)) begin
                op_b_w = stack_q[i];
            end
        end
    end

    assign bus.op_valid  = (count_q >= TWO_C);
    assign bus.op_a      = op_a_w;
    assign bus.op_b      = op_b_w;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == DEPTH_C);
    assign bus.empty     = (count_q == '0);
    assign bus.disp_mag  = disp_q[WIDTH-1:0];
    assign bus.disp_sign = disp_q[WIDTH];
    assign bus.disp_ovf  = disp_q[WIDTH+1];
    assign bus.stk_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_operand_stack_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_stack_buffer
// Purpose : Scoreboard bench for operand_stack_buffer (WIDTH=8, DEPTH=4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_operand_stack_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        int         count;
        logic [2:0] flags;   // {full, empty, op_valid}
        logic [9:0] op_a;
        logic [9:0] op_b;
        logic [9:0] disp;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    exp_t       exp_q [$];
    logic [9:0] m_stk [$];
    logic [8:0] m_entry;
    logic [9:0] m_disp;
    logic       m_err;

    operand_stack_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_stack_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, clr, sd, ent, rr, tk,
                         input logic [8:0] din, res, input bit rovf);
        if (r || clr) begin
            m_stk.delete();
            m_entry = '0;
            m_disp  = '0;
            m_err   = 1'b0;
        end else begin
            if (tk && m_stk.size() >= 2) begin
                void'(m_stk.pop_back());
                void'(m_stk.pop_back());
            end
            if (rr) begin
                if (m_stk.size() < DEPTH) m_stk.push_back({rovf, res});
                else m_err = 1'b1;
            end
            if (ent && !sd) begin
                if (m_stk.size() < DEPTH) m_stk.push_back({1'b0, m_entry});
                else m_err = 1'b1;
                m_entry = '0;
            end
            if (sd)           m_disp = {1'b0, din};
            else if (ent)     m_disp = '0;
            else if (rr)      m_disp = {rovf, res};
            if (sd) m_entry = din;
        end
    endtask

    task automatic step(input bit r, clr, sd, ent, rr, tk,
                        input logic [8:0] din, res, input bit rovf);
        exp_t e;
        int   n;
        @(negedge clk);
        rst              = r;
        bus.clear        = clr;
        bus.store_digit  = sd;
        bus.enter        = ent;
        bus.result_ready = rr;
        bus.op_take      = tk;
        bus.digit_in     = din;
        bus.result       = res;
        bus.result_ovf   = rovf;
        model(r, clr, sd, ent, rr, tk, din, res, rovf);
        n       = m_stk.size();
        e.count = n;
        e.flags = {n == DEPTH, n == 0, n >= 2};
        e.op_a  = (n >= 2) ? m_stk[n-2] : '0;
        e.op_b  = (n >= 2) ? m_stk[n-1] : '0;
        e.disp  = m_disp;
        e.err   = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("count", 32'(bus.count), 32'(e.count));
        chk("flags", 32'({bus.full, bus.empty, bus.op_valid}), 32'(e.flags));
        chk("op_a",  32'(bus.op_a), 32'(e.op_a));
        chk("op_b",  32'(bus.op_b), 32'(e.op_b));
        chk("disp",  32'({bus.disp_ovf, bus.disp_sign, bus.disp_mag}), 32'(e.disp));
        chk("err",   32'(bus.stk_err), 32'(e.err));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic push_val(input logic [8:0] v);
        step(0, 0, 1, 0, 0, 0, v, '0, 0);
        step(0, 0, 0, 1, 0, 0, '0, '0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.clear = 0; bus.store_digit = 0; bus.enter = 0; bus.result_ready = 0;
        bus.op_take = 0; bus.digit_in = '0; bus.result = '0; bus.result_ovf = 0;
        m_entry = '0; m_disp = '0; m_err = 0;

        step(1, 0, 0, 0, 0, 0, '0, '0, 0);
        chk("rst_empty", 32'(bus.empty), 32'd1);

        // T1: keyed-in negative operand shows on display, then commits
        step(0, 0, 1, 0, 0, 0, 9'h105, '0, 0);
        chk("t1_disp", 32'({bus.disp_sign, bus.disp_mag}), 32'h105);
        step(0, 0, 0, 1, 0, 0, '0, '0, 0);
        chk("t1_count", 32'(bus.count), 32'd1);

        // T2: op_a is the older entry, op_b the newer one
        step(1, 0, 0, 0, 0, 0, '0, '0, 0);
        push_val(9'd3);
        push_val(9'd7);
        chk("t2_op_a", 32'(bus.op_a), 32'd3);
        chk("t2_op_b", 32'(bus.op_b), 32'd7);
        step(0, 0, 0, 0, 0, 1, '0, '0, 0);

        // T3: take and result in the same cycle
        push_val(9'd1);
        push_val(9'd2);
        step(0, 0, 0, 0, 1, 1, '0, 9'h00A, 1);
        chk("t3_count", 32'(bus.count), 32'd1);
        chk("t3_ovf", 32'(bus.disp_ovf), 32'd1);
        push_val(9'd4);
        chk("t3_slot0", 32'(bus.op_a), 32'h20A);

        // T4: overfill, then clear
        step(0, 1, 0, 0, 0, 0, '0, '0, 0);
        for (int i = 1; i <= DEPTH; i++) push_val(9'(i * 16));
        push_val(9'h0FF);
        chk("t4_err", 32'(bus.stk_err), 32'd1);
        chk("t4_count", 32'(bus.count), 32'd4);
        step(0, 0, 0, 0, 0, 1, '0, '0, 0);
        push_val(9'd0);
        chk("t4_entry_clr", 32'(bus.op_b), 32'd0);
        step(0, 1, 0, 0, 0, 0, '0, '0, 0);

        // T5: one free slot goes to the result, entry dropped
        for (int i = 1; i <= 3; i++) push_val(9'(i));
        step(0, 0, 1, 0, 0, 0, 9'd9, '0, 0);
        step(0, 0, 0, 1, 1, 0, '0, 9'h044, 0);
        chk("t5_full", 32'(bus.full), 32'd1);
        chk("t5_top", 32'(bus.op_b), 32'h044);
        idle();

        // T6: store beats enter; take with a single entry is ignored
        step(0, 1, 0, 0, 0, 0, '0, '0, 0);
        step(0, 0, 1, 1, 0, 0, 9'd5, '0, 0);
        chk("t6_count0", 32'(bus.count), 32'd0);
        step(0, 0, 0, 1, 0, 0, '0, '0, 0);
        step(0, 0, 0, 0, 0, 1, '0, '0, 0);
        chk("t6_count1", 32'(bus.count), 32'd1);

        // Mixed traffic, including occasional clear and reset mid-sequence
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 9'($urandom), 9'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
